// File: rtl/data_memory_if.sv
// Load/store request and response channel between the execute stage and the data memory.
// The master drives the request side and accepts responses; the slave is the memory.
interface data_memory_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );
endinterface

// File: rtl/data_memory.sv
// RV32I word-organised data memory: one load/store per valid/ready request with
// byte/half/word lanes, sign/zero extension and illegal-access detection.
module data_memory #(
    parameter int DEPTH_WORDS = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    data_memory_if.slave  bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic {S_IDLE = 1'b0, S_RESP = 1'b1} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;
    logic        r_error;

    logic          w_accept;
    logic          w_bad_f3;
    logic          w_misalign;
    logic          w_oob;
    logic          w_error;
    logic [AW-1:0] w_idx;
    logic [1:0]    w_lane;
    logic [31:0]   w_word;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_load;
    logic [3:0]    w_be;
    logic [31:0]   w_wword;

    function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
        return {{24{sgn & b[7]}}, b};
    endfunction

    function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
        return {{16{sgn & h[15]}}, h};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.req_valid)  w_next = S_RESP;
            S_RESP:  if (bus.rsp_ready)  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = (r_state == S_IDLE);
        bus.rsp_valid = (r_state == S_RESP);
        bus.rsp_rdata = r_rdata;
        bus.rsp_error = r_error;
    end

    assign w_accept = bus.req_valid && (r_state == S_IDLE);
    assign w_idx    = bus.req_addr[AW+1:2];
    assign w_lane   = bus.req_addr[1:0];

    // funct3[1:0] is the access size, funct3[2] the unsigned-load flag (illegal for stores)
    assign w_bad_f3   = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11) ||
                        (bus.req_write && bus.req_funct3[2]);
    assign w_misalign = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                        ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    assign w_oob      = |bus.req_addr[31:AW+2];
    assign w_error    = w_bad_f3 || w_misalign || w_oob;

    always_comb begin
        w_be    = 4'b1111;
        w_wword = bus.req_wdata;
        case (bus.req_funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << w_lane;
                w_wword = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wword = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wword = bus.req_wdata;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_accept && bus.req_write && !w_error) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wword[8*b +: 8];
            end
        end
    end

    assign w_word = r_mem[w_idx];
    assign w_byte = w_word[8*w_lane +: 8];
    assign w_half = w_lane[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_load = 32'd0;
        case (bus.req_funct3)
            3'b000:  w_load = ext8(w_byte, 1'b1);
            3'b100:  w_load = ext8(w_byte, 1'b0);
            3'b001:  w_load = ext16(w_half, 1'b1);
            3'b101:  w_load = ext16(w_half, 1'b0);
            3'b010:  w_load = w_word;
            default: w_load = 32'd0;
        endcase
    end

    // Response is captured only on accept, so it stays frozen while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= 32'd0;
            r_error <= 1'b0;
        end else if (w_accept) begin
            r_error <= w_error;
            r_rdata <= (w_error || bus.req_write) ? 32'd0 : w_load;
        end
    end
endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: directed load/store sequence followed by random traffic,
// both checked against a byte-addressed reference model of the memory.
module tb_data_memory;
    localparam int DEPTH = 64;
    localparam int BYTES = 4 * DEPTH;

    logic clk;
    logic rst_n;
    data_memory_if bus ();

    data_memory #(.DEPTH_WORDS(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] mem_ref [BYTES];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void ref_access(input bit w, input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] wd, output logic [31:0] rd,
                                       output logic er);
        int size;
        logic [31:0] v;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        er = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) ||
             (w && (f3 == 3'd4 || f3 == 3'd5)) ||
             ((a % size) != 0) || (a >= BYTES);
        rd = 32'd0;
        if (!er) begin
            if (w) begin
                for (int i = 0; i < size; i++) mem_ref[a + i] = wd[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < size; i++) v[8*i +: 8] = mem_ref[a + i];
                if (!f3[2] && size < 4 && v[8*size-1])
                    for (int i = size; i < 4; i++) v[8*i +: 8] = 8'hFF;
                rd = v;
            end
        end
    endfunction

    task automatic xact(input bit w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int hold, input bit intrude,
                        output logic [31:0] rd, output logic er);
        logic [31:0] exp_rd;
        logic        exp_er;
        @(negedge clk);
        bus.rsp_ready  = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_write  = w;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        @(posedge clk); #1;
        ref_access(w, f3, a, wd, exp_rd, exp_er);
        rd = bus.rsp_rdata;
        er = bus.rsp_error;
        check("rsp_valid_after_accept", {31'd0, bus.rsp_valid}, 32'd1);
        check("req_ready_in_resp", {31'd0, bus.req_ready}, 32'd0);
        check("rsp_rdata", rd, exp_rd);
        check("rsp_error", {31'd0, er}, {31'd0, exp_er});
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (intrude) begin
                bus.req_valid  = 1'b1;
                bus.req_write  = 1'b1;
                bus.req_funct3 = 3'b010;
                bus.req_addr   = a & 32'hFFFF_FFFC;
                bus.req_wdata  = 32'hDEAD_BEEF;
            end else begin
                bus.req_valid = 1'b0;
            end
            @(posedge clk); #1;
            check("hold_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            check("hold_req_ready", {31'd0, bus.req_ready}, 32'd0);
            check("hold_rdata", bus.rsp_rdata, rd);
            check("hold_error", {31'd0, bus.rsp_error}, {31'd0, er});
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("rsp_valid_after_handshake", {31'd0, bus.rsp_valid}, 32'd0);
        check("req_ready_after_handshake", {31'd0, bus.req_ready}, 32'd1);
    endtask

    task automatic dchk(input string tag, input logic [31:0] rd, input logic er,
                        input logic [31:0] exp_rd, input logic exp_er);
        check({tag, "_rdata"}, rd, exp_rd);
        check({tag, "_error"}, {31'd0, er}, {31'd0, exp_er});
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] ra;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        bus.rsp_ready  = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("reset_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("reset_rsp_error", {31'd0, bus.rsp_error}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < DEPTH; i++) xact(1'b1, 3'b010, 32'(4 * i), $urandom, 0, 1'b0, rd, er);

        xact(1'b1, 3'b010, 32'h10, 32'h1234_5678, 0, 1'b0, rd, er);
        dchk("sw_10", rd, er, 32'h0, 1'b0);
        xact(1'b0, 3'b010, 32'h10, 32'h0, 0, 1'b0, rd, er);
        dchk("lw_10", rd, er, 32'h1234_5678, 1'b0);
        xact(1'b1, 3'b000, 32'h13, 32'h0000_00AB, 0, 1'b0, rd, er);
        xact(1'b0, 3'b000, 32'h13, 32'h0, 0, 1'b0, rd, er);
        dchk("lb_13", rd, er, 32'hFFFF_FFAB, 1'b0);
        xact(1'b0, 3'b100, 32'h13, 32'h0, 0, 1'b0, rd, er);
        dchk("lbu_13", rd, er, 32'h0000_00AB, 1'b0);
        xact(1'b0, 3'b010, 32'h10, 32'h0, 0, 1'b0, rd, er);
        dchk("lw_after_sb", rd, er, 32'hAB34_5678, 1'b0);
        xact(1'b1, 3'b001, 32'h12, 32'h0000_8001, 0, 1'b0, rd, er);
        xact(1'b0, 3'b001, 32'h12, 32'h0, 0, 1'b0, rd, er);
        dchk("lh_12", rd, er, 32'hFFFF_8001, 1'b0);
        xact(1'b0, 3'b101, 32'h12, 32'h0, 0, 1'b0, rd, er);
        dchk("lhu_12", rd, er, 32'h0000_8001, 1'b0);
        xact(1'b0, 3'b010, 32'h10, 32'h0, 0, 1'b0, rd, er);
        dchk("lw_after_sh", rd, er, 32'h8001_5678, 1'b0);

        xact(1'b1, 3'b010, 32'h11, 32'hFFFF_FFFF, 0, 1'b0, rd, er);
        dchk("err_sw_misalign", rd, er, 32'h0, 1'b1);
        xact(1'b0, 3'b001, 32'h13, 32'h0, 0, 1'b0, rd, er);
        dchk("err_lh_misalign", rd, er, 32'h0, 1'b1);
        xact(1'b1, 3'b000, 32'h100, 32'h0000_0055, 0, 1'b0, rd, er);
        dchk("err_sb_oob", rd, er, 32'h0, 1'b1);
        xact(1'b0, 3'b011, 32'h10, 32'h0, 0, 1'b0, rd, er);
        dchk("err_load_f3_011", rd, er, 32'h0, 1'b1);
        xact(1'b1, 3'b100, 32'h10, 32'h0000_0077, 0, 1'b0, rd, er);
        dchk("err_store_f3_100", rd, er, 32'h0, 1'b1);
        xact(1'b0, 3'b010, 32'h10, 32'h0, 0, 1'b0, rd, er);
        dchk("lw_after_errors", rd, er, 32'h8001_5678, 1'b0);
        xact(1'b0, 3'b000, 32'h0, 32'h0, 0, 1'b0, rd, er);
        dchk("lb_0_unchanged_by_sb_oob", {24'd0, rd[7:0]}, er, {24'd0, mem_ref[0]}, 1'b0);

        xact(1'b0, 3'b010, 32'h10, 32'h0, 3, 1'b1, rd, er);
        dchk("lw_backpressure", rd, er, 32'h8001_5678, 1'b0);
        xact(1'b0, 3'b010, 32'h10, 32'h0, 0, 1'b0, rd, er);
        dchk("lw_after_ignored_sw", rd, er, 32'h8001_5678, 1'b0);

        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h10;
        @(posedge clk); #1;
        check("rst_pre_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        bus.req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_mid_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_mid_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("rst_mid_rsp_error", {31'd0, bus.rsp_error}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        xact(1'b0, 3'b010, 32'h10, 32'h0, 0, 1'b0, rd, er);
        dchk("lw_after_reset", rd, er, 32'h8001_5678, 1'b0);

        for (int n = 0; n < 200; n++) begin
            ra = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(BYTES, 4 * BYTES))
                                             : 32'($urandom_range(0, BYTES - 1));
            xact(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom,
                 int'($urandom_range(0, 2)), 1'b0, rd, er);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/data_memory.md
# data_memory

Word-organised RV32I data memory, the load/store counterpart to the read-only instruction ROM. It accepts one load or store per request over a valid/ready handshake and applies RV32I byte, halfword and word semantics using `funct3` directly from the instruction. Loads are returned with sign or zero extension, and illegal accesses are flagged. It sits between the execute stage (address from the ALU, store data from register file port 2) and register-file writeback.

## Interface
- `DEPTH_WORDS`, default 64: number of 32-bit words; power of two, ≥4; addressable bytes = 4·DEPTH_WORDS.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  block can accept a request
- `req_write`  in  1  1 = store, 0 = load
- `req_funct3`  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  store data; low byte/half/word used
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  consumer accepts response
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors
- `rsp_error`  out  1  request was illegal and had no effect

## Operation
- Two-state FSM: IDLE → RESP on accept (`req_valid && req_ready`). RESP → IDLE when `rsp_valid && rsp_ready`.
- `req_ready` = (state == IDLE). `rsp_valid` = (state == RESP). Both are registered-state-derived, with no combinational path from inputs.
- Word index = `req_addr[log2(DEPTH_WORDS)+1:2]`. Byte lane = `req_addr[1:0]`. Layout is little-endian.
- Error conditions, any of which sets `rsp_error=1`, suppresses the write and forces `rsp_rdata=0`:
  - `funct3` ∈ {011, 110, 111}.
  - Store with `funct3` ∈ {100, 101}.
  - Halfword access with `addr[0]=1`.
  - Word access with `addr[1:0]≠0`.
  - `req_addr ≥ 4·DEPTH_WORDS`.
- Store (legal):
  - SB writes `wdata[7:0]` to the lane.
  - SH writes `wdata[15:0]` to lanes {addr[1],0} and {addr[1],1}.
  - SW writes the whole word.
  - Other lanes are unchanged; the write is committed at the accept edge.
- Load (legal):
  - LB sign-extends the lane byte; LBU zero-extends it.
  - LH sign-extends the halfword selected by `addr[1]`; LHU zero-extends it.
  - LW returns the word.
- Response fields are captured at the accept edge and held stable while in RESP.
- Memory array is not reset; contents are undefined until written.

## Timing
- Reset values: state IDLE, `req_ready=1`, `rsp_valid=0`, `rsp_rdata=0`, `rsp_error=0`.
- Latency: a request accepted at edge N gives `rsp_valid=1` from edge N until edge M, where M is the first edge with `rsp_ready=1`. `req_ready` returns to 1 after M.
- Peak throughput is one request per 2 cycles, reached when `rsp_ready` is held at 1.
- Backpressure: while in RESP, `rsp_rdata` and `rsp_error` are stable and `req_valid` is ignored, with no write and no capture.
- Reset mid-operation:
  - `rst_n` low immediately forces `rsp_valid=0`, `req_ready=1` and clears `rsp_rdata` and `rsp_error`.
  - A pending response is dropped.
  - A store committed at an earlier edge persists.
- A request presented in the same cycle as `rsp_valid && rsp_ready` is not accepted; it is accepted in the next cycle.
- A load of a word stored by the immediately preceding request returns the new data; the store is committed before the next accept.

## Test plan
- SW 0x12345678 @0x10, then LW @0x10: `rsp_rdata`=0x12345678, `rsp_error`=0, `rsp_valid` high at the edge after each accept.
- After the above, SB 0x000000AB @0x13:
  - LB @0x13 → 0xFFFFFFAB.
  - LBU @0x13 → 0x000000AB.
  - LW @0x10 → 0xAB345678.
- SH 0x00008001 @0x12:
  - LH @0x12 → 0xFFFF8001.
  - LHU @0x12 → 0x00008001.
  - LW @0x10 → 0x80015678.
- Illegal requests, each → `rsp_error`=1, `rsp_rdata`=0, memory unchanged:
  - SW @0x11.
  - LH @0x13.
  - SB @0x100 with DEPTH_WORDS=64.
  - Load with funct3=011.
  - Store with funct3=100.
- Backpressure: hold `rsp_ready`=0 for 3 cycles after an LW; `rsp_valid` and `rsp_rdata` stay stable and `req_ready`=0. Concurrent `req_valid` with an SW is ignored: the memory word is unchanged.
- Assert `rst_n`=0 while in RESP: `rsp_valid` drops in the same cycle. After release, `req_ready`=1, and the earlier-stored word at 0x10 still reads back.
